// File: rtl/input_debounce_if.sv
// Signal bundle between the raw-pad conditioner and its consumers.
// The master drives pads and clears; the slave (debouncer) returns levels and events.
interface input_debounce_if #(
  parameter int WIDTH = 21
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] sticky;

  modport master (
    output raw_in,
    output clr,
    input  db_out,
    input  rise,
    input  fall,
    input  sticky
  );

  modport slave (
    input  raw_in,
    input  clr,
    output db_out,
    output rise,
    output fall,
    output sticky
  );
endinterface

// File: rtl/input_debounce.sv
// Per-bit 2-FF synchroniser plus counter debouncer for the Basys3 switches and buttons.
// Produces debounced levels, single-cycle edge pulses and a CPU-clearable press latch.
module input_debounce #(
  parameter int WIDTH    = 21,
  parameter int DB_COUNT = 100000
) (
  input logic             clk,
  input logic             rst_n,
  input_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(DB_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] done;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic [CNT_W-1:0] cnt [WIDTH];

  // A bit flips when s2 has disagreed with the level for DB_COUNT straight cycles.
  always_comb begin
    done = '0;
    for (int i = 0; i < WIDTH; i++) begin
      done[i] = (s2[i] != bus.db_out[i]) && (cnt[i] == LAST);
    end
    rise_next = done & s2;
    fall_next = done & ~s2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      bus.db_out <= '0;
      bus.rise   <= '0;
      bus.fall   <= '0;
      bus.sticky <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= bus.raw_in;
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == bus.db_out[i] || done[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      bus.db_out <= bus.db_out ^ done;
      bus.rise   <= rise_next;
      bus.fall   <= fall_next;
      // A rise on the same edge as a clear keeps the latch set.
      bus.sticky <= (bus.sticky & ~bus.clr) | rise_next;
    end
  end

endmodule
